// File: rtl/test_mon_pkg.sv
// rtl/test_mon_pkg.sv - shared types and widths for the test-end monitor
package test_mon_pkg;

  localparam int CAUSE_W = 2;
  localparam int CNT_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_TRAP   = 3'd2,
    ST_RUN    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } mon_state_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_ISA  = 2'd1,
    CAUSE_SW   = 2'd2,
    CAUSE_TMO  = 2'd3
  } end_cause_e;

endpackage

// File: rtl/mon_dcnt.sv
// rtl/mon_dcnt.sv - loadable down-counter with zero flag, stops at zero
module mon_dcnt
  import test_mon_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/test_end_monitor.sv
// rtl/test_end_monitor.sv - trap stimulus, end-of-test detection, watchdog and verdict latch
module test_end_monitor
  import test_mon_pkg::*;
#(
  parameter int DW       = 32,
  parameter int NCH      = 2,
  parameter int TRAP_DLY = 900,
  parameter int TRAP_W   = 7,
  parameter int SETTLE   = 10,
  parameter int TIMEOUT  = 30000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_i,
  input  logic               pass_i,
  input  logic [DW-1:0]      testnum_i,
  input  logic [NCH-1:0]     end_i,
  output logic               trap_o,
  output logic               busy_o,
  output logic               end_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic [CAUSE_W-1:0] cause_o,
  output logic [NCH-1:0]     end_src_o,
  output logic [DW-1:0]      fail_num_o,
  output logic [DW-1:0]      cyc_o
);

  // The IDLE cycle is cycle 0, so DELAY lasts TRAP_DLY-1 cycles.
  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(TRAP_DLY > 1 ? TRAP_DLY - 2 : 0);
  localparam logic [CNT_W-1:0] TW_LD  = CNT_W'(TRAP_W > 0 ? TRAP_W - 1 : 0);
  localparam logic [CNT_W-1:0] ST_LD  = CNT_W'(SETTLE > 0 ? SETTLE - 1 : 0);
  localparam logic [DW-1:0]    TMO_LIM = DW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  mon_state_e       state_q, state_d;
  end_cause_e       cause_q, cause_d;
  logic             trap_q, busy_q, end_q, pass_q, fail_q;
  logic             pass_d, fail_d;
  logic [NCH-1:0]   end_src_q, end_src_d, end_clean;
  logic [DW-1:0]    fail_num_q, fail_num_d, cyc_q, cyc_d;
  logic             cnt_ld, cnt_zero, active, tmo_hit, isa_latch;
  logic [CNT_W-1:0] cnt_val;

  mon_dcnt #(.W(CNT_W)) u_dcnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_ld),
    .load_val_i(cnt_val),
    .en_i      (1'b1),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    end_clean = '0;
    for (int i = 0; i < NCH; i++) begin
      if (end_i[i]) end_clean[i] = 1'b1;
    end
    active     = (state_q == ST_DELAY) || (state_q == ST_TRAP) || (state_q == ST_RUN);
    tmo_hit    = (TIMEOUT > 0) && (cyc_q >= TMO_LIM);
    state_d    = state_q;
    cnt_ld     = 1'b0;
    cnt_val    = TW_LD;
    isa_latch  = 1'b0;
    cause_d    = cause_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    end_src_d  = end_src_q;
    fail_num_d = fail_num_q;

    case (state_q)
      ST_IDLE: begin
        cnt_ld = 1'b1;
        if (TRAP_DLY == 1) begin
          state_d = ST_TRAP;
        end else begin
          state_d = ST_DELAY;
          cnt_val = DLY_LD;
        end
      end
      ST_DELAY: begin
        if (TRAP_DLY == 0) begin
          state_d = ST_RUN;
        end else if (cnt_zero) begin
          state_d = ST_TRAP;
          cnt_ld  = 1'b1;
        end
      end
      ST_TRAP:   if (cnt_zero) state_d = ST_RUN;
      ST_SETTLE: if (cnt_zero) isa_latch = 1'b1;
      default: ;
    endcase

    // Same-cycle priority: ISA done, then software end, then watchdog.
    if (active) begin
      if (done_i) begin
        if (SETTLE == 0) begin
          isa_latch = 1'b1;
        end else begin
          state_d = ST_SETTLE;
          cnt_ld  = 1'b1;
          cnt_val = ST_LD;
        end
      end else if (|end_clean) begin
        state_d   = ST_DONE;
        cause_d   = CAUSE_SW;
        end_src_d = end_clean;
      end else if (tmo_hit) begin
        state_d = ST_DONE;
        cause_d = CAUSE_TMO;
      end
    end

    if (isa_latch) begin
      state_d    = ST_DONE;
      cause_d    = CAUSE_ISA;
      pass_d     = pass_i;
      fail_d     = !pass_i;
      fail_num_d = pass_i ? '0 : testnum_i;
    end

    // The count freezes on the deciding edge so cyc_o reports the latch cycle.
    cyc_d = cyc_q;
    if ((state_q != ST_DONE) && (state_d != ST_DONE) && (cyc_q != '1)) begin
      cyc_d = cyc_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      trap_q     <= 1'b0;
      busy_q     <= 1'b0;
      end_q      <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      cause_q    <= CAUSE_NONE;
      end_src_q  <= '0;
      fail_num_q <= '0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      trap_q     <= (state_d == ST_TRAP);
      busy_q     <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      end_q      <= (state_d == ST_DONE);
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      cause_q    <= cause_d;
      end_src_q  <= end_src_d;
      fail_num_q <= fail_num_d;
      cyc_q      <= cyc_d;
    end
  end

  assign trap_o     = trap_q;
  assign busy_o     = busy_q;
  assign end_o      = end_q;
  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign cause_o    = cause_q;
  assign end_src_o  = end_src_q;
  assign fail_num_o = fail_num_q;
  assign cyc_o      = cyc_q;

endmodule

// File: tb/tb_test_end_monitor.sv
// tb/tb_test_end_monitor.sv - bench for test_end_monitor
module tb_test_end_monitor;

  localparam int INF = 1 << 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_i, pass_i;
  logic [31:0] testnum_i;
  logic [1:0]  end_i;

  logic        a_trap, a_busy, a_end, a_pass, a_fail;
  logic [1:0]  a_cause, a_src;
  logic [31:0] a_fnum, a_cyc;
  logic        b_trap, b_busy, b_end, b_pass, b_fail;
  logic [1:0]  b_cause, b_src;
  logic [31:0] b_fnum, b_cyc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  test_end_monitor #(
    .DW(32), .NCH(2), .TRAP_DLY(900), .TRAP_W(7), .SETTLE(10), .TIMEOUT(3000)
  ) u_a (
    .clk(clk), .rst(rst), .done_i(done_i), .pass_i(pass_i), .testnum_i(testnum_i),
    .end_i(end_i), .trap_o(a_trap), .busy_o(a_busy), .end_o(a_end), .pass_o(a_pass),
    .fail_o(a_fail), .cause_o(a_cause), .end_src_o(a_src), .fail_num_o(a_fnum), .cyc_o(a_cyc)
  );

  test_end_monitor #(
    .DW(32), .NCH(2), .TRAP_DLY(0), .TRAP_W(7), .SETTLE(0), .TIMEOUT(0)
  ) u_b (
    .clk(clk), .rst(rst), .done_i(done_i), .pass_i(pass_i), .testnum_i(testnum_i),
    .end_i(end_i), .trap_o(b_trap), .busy_o(b_busy), .end_o(b_end), .pass_o(b_pass),
    .fail_o(b_fail), .cause_o(b_cause), .end_src_o(b_src), .fail_num_o(b_fnum), .cyc_o(b_cyc)
  );

  task automatic chk(input string who, input string f, input int c,
                     input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s %s cycle %0d observed=%0h expected=%0h", who, f, c, o, e);
    end
  endtask

  // Latch cycle and cause from the first qualifying event; events in cycle 0 (IDLE) do not exist here.
  task automatic model(input int settle, input int tmo, input int d, input int e,
                       output int l, output int cause);
    int best;
    best  = INF;
    cause = 0;
    if (d >= 1) begin best = d; cause = 1; end
    if (e >= 1 && e < best) begin best = e; cause = 2; end
    if (tmo > 0 && tmo - 1 < best) begin best = tmo - 1; cause = 3; end
    l = (cause == 1) ? d + settle : best;
  endtask

  task automatic exp_dut(input string who, input int c, input int tdly, input int tw,
                         input int l, input int cause, input int pf, input int pv,
                         input int tn, input int v,
                         input logic trap, input logic busy, input logic endo,
                         input logic pass, input logic fail, input logic [1:0] co,
                         input logic [1:0] src, input logic [31:0] fnum, input logic [31:0] cyc);
    logic        pvl, latched, e_trap;
    logic [1:0]  e_src, e_cause;
    logic [31:0] e_fnum, e_cyc;
    pvl     = (l >= pf) ? pv[0] : !pv[0];
    latched = (c > l);
    e_trap  = (tdly > 0) && (c >= tdly) && (c < tdly + tw) && (c <= l);
    e_cause = latched ? 2'(cause) : 2'd0;
    e_src   = (latched && cause == 2) ? 2'(v) : 2'd0;
    e_fnum  = (latched && cause == 1 && !pvl) ? 32'(tn) : 32'd0;
    e_cyc   = latched ? 32'(l) : 32'(c);
    chk(who, "trap_o", c, trap, e_trap);
    chk(who, "busy_o", c, busy, (c >= 1) && !latched);
    chk(who, "end_o", c, endo, latched);
    chk(who, "pass_o", c, pass, latched && cause == 1 && pvl);
    chk(who, "fail_o", c, fail, latched && cause == 1 && !pvl);
    chk(who, "cause_o", c, co, e_cause);
    chk(who, "end_src_o", c, src, e_src);
    chk(who, "fail_num_o", c, fnum, e_fnum);
    chk(who, "cyc_o", c, cyc, e_cyc);
  endtask

  // One run from reset release; a >= 0 asserts rst during cycle a and ends the run there.
  task automatic run(input string nm, input int d, input int pf, input int pv, input int tn,
                     input int e, input int v, input int a);
    int la, ca, lb, cb, lim, lmax;
    bit rnd_ok;
    model(10, 3000, d, e, la, ca);
    model(0, 0, d, e, lb, cb);
    rnd_ok = (lb < INF);
    lmax   = rnd_ok ? ((la > lb) ? la : lb) : la;
    lim    = (a >= 0) ? a : lmax + 6;
    for (int c = 0; c <= lim; c++) begin
      rst = (c == a);
      if (rnd_ok && c > lmax) begin
        done_i    = 1'($urandom);
        pass_i    = 1'($urandom);
        testnum_i = $urandom;
        end_i     = 2'($urandom);
      end else begin
        done_i    = (d >= 1 && c >= d);
        pass_i    = (c >= pf) ? pv[0] : !pv[0];
        testnum_i = (d >= 1 && c >= d) ? 32'(tn) : $urandom;
        end_i     = (e >= 1 && c >= e) ? 2'(v) : 2'd0;
      end
      @(negedge clk);
      exp_dut({nm, "/a"}, c, 900, 7, la, ca, pf, pv, tn, v,
              a_trap, a_busy, a_end, a_pass, a_fail, a_cause, a_src, a_fnum, a_cyc);
      exp_dut({nm, "/b"}, c, 0, 7, lb, cb, pf, pv, tn, v,
              b_trap, b_busy, b_end, b_pass, b_fail, b_cause, b_src, b_fnum, b_cyc);
      @(posedge clk);
      #1;
    end
    if (a < 0) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int d, e, v, pv, pf, tn;
    rst       = 1'b1;
    done_i    = 1'b0;
    pass_i    = 1'b0;
    testnum_i = '0;
    end_i     = '0;
    repeat (3) @(posedge clk);
    #1;

    run("isa_pass",  2000, 2005, 1, 32'h55,  -1, 0, -1);
    run("isa_fail",  1500, 0,    0, 32'h17,  -1, 0, -1);
    run("sw_mid",    -1,   0,    1, 0,       903, 2, -1);
    run("timeout",   -1,   0,    1, 0,       -1,  0, -1);
    run("tie",       1200, 0,    1, 32'h9,   1200, 1, -1);
    run("settle_wd", 2995, 2990, 0, 32'h3c,  -1,  0, -1);
    run("rst_mid",   -1,   0,    1, 0,       -1,  0, 904);
    run("after_rst", -1,   0,    1, 0,       1000, 3, -1);

    for (int r = 0; r < 6; r++) begin
      d  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 3100));
      e  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 3100));
      v  = int'($urandom_range(1, 3));
      pv = int'($urandom_range(0, 1));
      pf = int'($urandom_range(0, 3200));
      tn = int'($urandom);
      run($sformatf("rand%0d", r), d, pf, pv, tn, e, v, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_end_monitor.md
Name: test_end_monitor

Overview:
Synthesizable, parametrised monitor that moves the SoC test-sequencing and completion logic into RTL, so FPGA self-test builds can use it as well as simulation.
- After reset it drives one external-trap stimulus pulse at a programmable delay and width.
- It watches an ISA-test completion flag plus NCH software end sources, and runs a cycle watchdog.
- It latches a single verdict (pass / fail / software end / timeout) together with the failing test number and the cycle count at the end.
- It sits beside the core in the SoC and takes its observation signals from the core's register file and CSR block.

Parameters:
- DW, 32: width of the test-number capture and of the cycle counter.
- NCH, 2: number of software end-request inputs (for example CSR mends and a debug halt).
- TRAP_DLY, 900: cycles from reset release to trap pulse assertion; 0 disables the pulse.
- TRAP_W, 7: trap pulse width in cycles; must be at least 1.
- SETTLE, 10: cycles between seeing done_i and sampling pass_i / testnum_i.
- TIMEOUT, 30000: watchdog limit in cycles counted from reset release; 0 disables the watchdog.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset; one clock, reset is synchronous and active-high.
- done_i, in, 1: ISA-test completion (x26==1).
- pass_i, in, 1: ISA-test verdict (x27==1).
- testnum_i, in, DW: current test number (x3).
- end_i, in, NCH: software end requests; level-sensitive; X/Z is treated as 0.
- trap_o, out, 1: external trap stimulus to the core (ex_trap_i).
- busy_o, out, 1: monitor is active; no verdict yet.
- end_o, out, 1: a verdict is latched; sticky.
- pass_o, out, 1: ISA pass.
- fail_o, out, 1: ISA fail.
- cause_o, out, 2: 0 none, 1 ISA, 2 software end, 3 timeout.
- end_src_o, out, NCH: which end_i bits were high at the latch cycle.
- fail_num_o, out, DW: testnum_i sampled at the latch cycle; 0 otherwise.
- cyc_o, out, DW: cycle count at the latch cycle; free-running (saturating) while busy.

Behaviour:
- Reset values: trap_o=0, busy_o=0, end_o=0, pass_o=0, fail_o=0, cause_o=0, end_src_o=0, fail_num_o=0, cyc_o=0, FSM in IDLE.
- FSM states: IDLE, DELAY, TRAP, RUN, SETTLE, DONE.
- IDLE: entered during reset; moves to DELAY on the first cycle with rst=0. busy_o is 1 in every state except IDLE and DONE.
- DELAY: counts TRAP_DLY cycles, then moves to TRAP. With TRAP_DLY=0 it goes straight to RUN.
- TRAP: trap_o=1 for exactly TRAP_W cycles, then RUN. The first trap_o=1 cycle is cycle TRAP_DLY after reset release (cycle 0 = first cycle with rst=0).
- End detection is active in DELAY, TRAP and RUN, not only in RUN.
- Any end event forces trap_o=0 on the next cycle; the pulse is truncated.
- Priority in the same cycle: done_i first, then end_i, then timeout.
- done_i=1: move to SETTLE; count SETTLE cycles (SETTLE=0 means sample in the same cycle); then sample pass_i and testnum_i and go to DONE.
  - pass_i=1 gives pass_o=1, fail_num_o=0.
  - pass_i=0 gives fail_o=1, fail_num_o=testnum_i.
  - cause_o=1.
- Any end_i bit = 1: go to DONE directly; cause_o=2; end_src_o=end_i.
- Timeout:
  - cyc_o increments every cycle outside IDLE/DONE and saturates at 2^DW-1 without wrapping.
  - When cyc_o reaches TIMEOUT-1 with no end event: DONE, cause_o=3, pass_o=fail_o=0.
  - The watchdog keeps running during SETTLE. An expiry in SETTLE is ignored; the ISA verdict wins.
- DONE: all outputs hold until rst; inputs are ignored; end_o=1.
- rst asserted in any state, including mid-pulse or SETTLE: the next cycle shows reset values and the trap pulse ends immediately.
- Outputs are registered with 1-cycle latency from the deciding event to end_o. No combinational input-to-output paths.

Decomposition:
- Package test_mon_pkg:
  - enum mon_state_e for the six states.
  - enum end_cause_e for codes 0-3.
  - constant CAUSE_W=2.
- One sub-module, mon_dcnt: a reusable loadable down-counter (load value, enable, zero flag). Instantiated for the DELAY/TRAP/SETTLE timing, with the count shared across those states.
- The cycle counter stays inline.

Test Plan:
1. Default parameters; done_i rises at cycle 2000 with pass_i=1 from cycle 2005 -> trap_o high on cycles 900-906; end_o=1 at cycle 2011; pass_o=1, cause_o=1, cyc_o=2010.
2. done_i at cycle 1500, pass_i=0, testnum_i=0x17 -> fail_o=1, fail_num_o=0x17, cause_o=1; outputs hold after the inputs change.
3. end_i=2'b10 at cycle 903 (mid-pulse) -> trap_o=0 from cycle 904; end_o=1, cause_o=2, end_src_o=2'b10; pulse was 4 cycles long.
4. TIMEOUT=3000, no end inputs -> end_o=1 at cycle 3000, cause_o=3, cyc_o=2999, pass_o=fail_o=0.
5. done_i and end_i=2'b01 in the same cycle, and the watchdog expiring during SETTLE -> cause_o=1 in both cases.
6. rst pulsed at cycle 904 during the trap pulse -> all outputs at reset values next cycle; a new pulse starts 900 cycles after rst falls. TRAP_DLY=0 gives no pulse at all.
